inst_fetch_responder: RTL and testbench

- Memory-side responder for the instruction fetch request interface.
- Accepts a held request plus a 32-bit fetch address from the fetch unit.
- Reads one 32-bit word from a synchronous instruction SRAM, with 1-cycle read latency and configurable extra wait states.
- Returns the word with a single-cycle dataOk pulse. Misaligned or out-of-range fetches return a NOP and flag an error.

---
 rtl/fetch_bus_pkg.sv | 16 +
 rtl/inst_fetch_responder.sv | 127 ++++++++++++
 tb/tb_inst_fetch_responder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_bus_pkg.sv
// Shared types and defaults for the instruction fetch bus responder.
package fetch_bus_pkg;

   typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WAIT, RESP} fetch_resp_state_t;

   localparam logic [31:0] DEFAULT_NOP_INST  = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

   // Word-aligned and inside the 2^(addr_w+2)-byte SRAM window.
   function automatic logic fetch_addr_ok(input logic [31:0] off, input int unsigned addr_w);
      logic [32:0] lim;
      lim = 33'(1) << (addr_w + 2);
      return (off[1:0] == 2'b00) && ({1'b0, off} < lim);
   endfunction

endpackage

// File: rtl/inst_fetch_responder.sv
// Memory-side responder for instruction fetches: one SRAM word per request,
// optional wait states, NOP plus error flag for bad addresses.
module inst_fetch_responder
   import fetch_bus_pkg::*;
#(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter logic [31:0] NOP_INST    = DEFAULT_NOP_INST
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              request_i,
   input  logic [31:0]       instAddr_i,
   input  logic              flush_i,
   output logic              dataOk_o,
   output logic [31:0]       inst_o,
   output logic              err_o,
   output logic              busy_o,
   output logic              mem_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [31:0]       mem_rdata_i
);

   localparam int unsigned CNT_W = 4;

   fetch_resp_state_t r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [31:0]       r_inst, w_inst_nxt;
   logic              r_err, w_err_nxt;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
   logic              r_mem_en, r_data_ok, r_busy;
   logic [31:0]       w_off;

   assign w_off = instAddr_i - BASE_ADDR;

   // State and all outputs are registered from the next-state decode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_inst     <= '0;
         r_err      <= 1'b0;
         r_mem_addr <= '0;
         r_mem_en   <= 1'b0;
         r_data_ok  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_inst     <= w_inst_nxt;
         r_err      <= w_err_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_mem_en   <= (w_state_nxt == ISSUE);
         r_data_ok  <= (w_state_nxt == RESP);
         r_busy     <= (w_state_nxt != IDLE);
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_inst_nxt     = r_inst;
      w_err_nxt      = r_err;
      w_mem_addr_nxt = r_mem_addr;
      case (r_state)
         IDLE: begin
            if (flush_i) begin
               w_cnt_nxt = '0;
            end else if (request_i) begin
               if (fetch_addr_ok(w_off, ADDR_W)) begin
                  w_mem_addr_nxt = w_off[ADDR_W+1:2];
                  w_state_nxt    = ISSUE;
               end else begin
                  w_inst_nxt  = NOP_INST;
                  w_err_nxt   = 1'b1;
                  w_state_nxt = RESP;
               end
            end
         end
         ISSUE: begin
            // A flushed read still completes in the SRAM; its data is simply never captured.
            if (flush_i) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            if (flush_i) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_inst_nxt = mem_rdata_i;
               w_err_nxt  = 1'b0;
               if (WAIT_CYCLES > 0) begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
               end else begin
                  w_state_nxt = RESP;
               end
            end
         end
         WAIT: begin
            if (flush_i) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == '0) begin
               w_state_nxt = RESP;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign dataOk_o   = r_data_ok;
   assign inst_o     = r_inst;
   assign err_o      = r_err;
   assign busy_o     = r_busy;
   assign mem_en_o   = r_mem_en;
   assign mem_addr_o = r_mem_addr;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench: one responder with no wait states and one with two.
module tb_inst_fetch_responder;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        req0 = 1'b0, flush0 = 1'b0, ok0, err0, busy0, en0;
   logic [31:0] addr0 = '0, inst0, rdata0 = '0;
   logic [11:0] maddr0;
   logic        req2 = 1'b0, flush2 = 1'b0, ok2, err2, busy2, en2;
   logic [31:0] addr2 = '0, inst2, rdata2 = '0;
   logic [11:0] maddr2;

   int ntests = 0;
   int nfail  = 0;

   inst_fetch_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset), .request_i(req0), .instAddr_i(addr0), .flush_i(flush0),
      .dataOk_o(ok0), .inst_o(inst0), .err_o(err0), .busy_o(busy0),
      .mem_en_o(en0), .mem_addr_o(maddr0), .mem_rdata_i(rdata0));

   inst_fetch_responder #(.ADDR_W(12), .WAIT_CYCLES(2)) u_dut2 (
      .clk(clk), .reset(reset), .request_i(req2), .instAddr_i(addr2), .flush_i(flush2),
      .dataOk_o(ok2), .inst_o(inst2), .err_o(err2), .busy_o(busy2),
      .mem_en_o(en2), .mem_addr_o(maddr2), .mem_rdata_i(rdata2));

   function automatic logic [31:0] sram_word(input logic [11:0] a);
      return (a == 12'd4) ? 32'h00A0_0093 : {20'h5A000, a};
   endfunction

   // Synchronous SRAM models, one-cycle read latency.
   always @(posedge clk) begin
      if (en0) rdata0 <= sram_word(maddr0);
      if (en2) rdata2 <= sram_word(maddr2);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one fetch on the zero-wait instance; lat is -1 if no response within the budget.
   task automatic fetch0(input logic [31:0] a, output int lat, output int en_at, output int en_cnt,
                         output logic [11:0] ma, output logic [31:0] ins, output logic er,
                         output logic ok_after);
      lat = -1; en_at = -1; en_cnt = 0; ma = '0; ins = '0; er = 1'b0;
      req0 = 1'b1; addr0 = a;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (en0) begin
            en_cnt++;
            if (en_at < 0) begin en_at = c; ma = maddr0; end
         end
         if (ok0) begin
            lat = c; ins = inst0; er = err0; req0 = 1'b0;
            break;
         end
      end
      req0 = 1'b0;
      step();
      ok_after = ok0;
   endtask

   task automatic test_reset();
      ntests++; if ({ok0, err0, busy0, en0} !== 4'b0) begin nfail++; $display("FAIL reset_ctl0 got=%b exp=0000", {ok0, err0, busy0, en0}); end
      ntests++; if (inst0 !== 32'h0) begin nfail++; $display("FAIL reset_inst0 got=%h exp=0", inst0); end
      ntests++; if (maddr0 !== 12'h0) begin nfail++; $display("FAIL reset_maddr0 got=%h exp=0", maddr0); end
      ntests++; if ({ok2, err2, busy2, en2} !== 4'b0) begin nfail++; $display("FAIL reset_ctl2 got=%b exp=0000", {ok2, err2, busy2, en2}); end
   endtask

   task automatic test_good_read();
      int lat, en_at, en_cnt; logic [11:0] ma; logic [31:0] ins; logic er, oka;
      fetch0(32'h8000_0010, lat, en_at, en_cnt, ma, ins, er, oka);
      ntests++; if (lat !== 3) begin nfail++; $display("FAIL good_latency got=%0d exp=3", lat); end
      ntests++; if (en_at !== 1 || en_cnt !== 1) begin nfail++; $display("FAIL good_mem_en at=%0d cnt=%0d exp at=1 cnt=1", en_at, en_cnt); end
      ntests++; if (ma !== 12'd4) begin nfail++; $display("FAIL good_mem_addr got=%h exp=004", ma); end
      ntests++; if (ins !== 32'h00A0_0093 || er !== 1'b0) begin nfail++; $display("FAIL good_inst got=%h err=%b exp=00a00093 err=0", ins, er); end
      ntests++; if (oka !== 1'b0) begin nfail++; $display("FAIL good_single_pulse got=%b exp=0", oka); end
   endtask

   task automatic test_bad_addr();
      logic [31:0] bad [3];
      int lat, en_at, en_cnt; logic [11:0] ma; logic [31:0] ins; logic er, oka;
      bad[0] = 32'h8000_0002; bad[1] = 32'h7FFF_FFFC; bad[2] = 32'h8000_4000;
      for (int i = 0; i < 3; i++) begin
         fetch0(bad[i], lat, en_at, en_cnt, ma, ins, er, oka);
         ntests++; if (lat !== 1) begin nfail++; $display("FAIL bad_latency[%0d] got=%0d exp=1", i, lat); end
         ntests++; if (ins !== 32'h0000_0013 || er !== 1'b1) begin nfail++; $display("FAIL bad_resp[%0d] got=%h err=%b exp=00000013 err=1", i, ins, er); end
         ntests++; if (en_cnt !== 0) begin nfail++; $display("FAIL bad_mem_en[%0d] got=%0d exp=0", i, en_cnt); end
         ntests++; if (oka !== 1'b0) begin nfail++; $display("FAIL bad_single_pulse[%0d] got=%b exp=0", i, oka); end
      end
   endtask

   task automatic test_last_word();
      int lat, en_at, en_cnt; logic [11:0] ma; logic [31:0] ins; logic er, oka;
      fetch0(32'h8000_3FFC, lat, en_at, en_cnt, ma, ins, er, oka);
      ntests++; if (lat !== 3 || ma !== 12'hFFF) begin nfail++; $display("FAIL last_word lat=%0d addr=%h exp lat=3 addr=fff", lat, ma); end
      ntests++; if (ins !== 32'h5A00_0FFF || er !== 1'b0) begin nfail++; $display("FAIL last_word_inst got=%h err=%b exp=5a000fff err=0", ins, er); end
      step();
      ntests++; if (inst0 !== 32'h5A00_0FFF) begin nfail++; $display("FAIL inst_hold got=%h exp=5a000fff", inst0); end
   endtask

   task automatic test_wait_states();
      logic [7:0] okv, busyv; logic [31:0] ins;
      okv = '0; busyv = '0; ins = '0;
      req2 = 1'b1; addr2 = 32'h8000_0010;
      for (int c = 1; c <= 7; c++) begin
         step();
         okv[c] = ok2; busyv[c] = busy2;
         if (ok2) begin ins = inst2; req2 = 1'b0; end
      end
      req2 = 1'b0;
      ntests++; if (okv !== 8'b0010_0000) begin nfail++; $display("FAIL wait_ok_cycles got=%b exp=00100000", okv); end
      ntests++; if (busyv !== 8'b0011_1110) begin nfail++; $display("FAIL wait_busy_cycles got=%b exp=00111110", busyv); end
      ntests++; if (ins !== 32'h00A0_0093) begin nfail++; $display("FAIL wait_inst got=%h exp=00a00093", ins); end
   endtask

   task automatic test_flush();
      int lat; int early;
      lat = -1; early = 0;
      req0 = 1'b1; addr0 = 32'h8000_0010;
      step();          // ISSUE
      step();          // CAPTURE
      flush0 = 1'b1;
      step();          // IDLE after flush
      ntests++; if (busy0 !== 1'b0 || ok0 !== 1'b0) begin nfail++; $display("FAIL flush_idle busy=%b ok=%b exp 0 0", busy0, ok0); end
      flush0 = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (ok0) begin lat = c; req0 = 1'b0; break; end
      end
      req0 = 1'b0;
      ntests++; if (lat !== 3) begin nfail++; $display("FAIL flush_reaccept_latency got=%0d exp=3", lat); end
      step();
   endtask

   task automatic test_back_to_back();
      int pulses; int at [3]; logic consec; logic prev;
      pulses = 0; consec = 1'b0; prev = 1'b0;
      at[0] = -1; at[1] = -1; at[2] = -1;
      req0 = 1'b1; addr0 = 32'h8000_0010;
      for (int c = 1; c <= 16; c++) begin
         step();
         if (ok0 && prev) consec = 1'b1;
         prev = ok0;
         if (ok0) begin
            if (pulses < 3) at[pulses] = c;
            pulses++;
            if (pulses == 3) req0 = 1'b0;
         end
      end
      req0 = 1'b0;
      ntests++; if (pulses !== 3) begin nfail++; $display("FAIL b2b_pulse_count got=%0d exp=3", pulses); end
      ntests++; if (at[0] !== 3 || at[1] !== 7 || at[2] !== 11) begin nfail++; $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=3,7,11", at[0], at[1], at[2]); end
      ntests++; if (consec !== 1'b0) begin nfail++; $display("FAIL b2b_consecutive got=%b exp=0", consec); end
   endtask

   task automatic test_reset_in_wait();
      int stray;
      stray = 0;
      req2 = 1'b1; addr2 = 32'h8000_0010;
      step(); step(); step();   // first WAIT cycle
      ntests++; if (busy2 !== 1'b1) begin nfail++; $display("FAIL rst_wait_precond busy=%b exp=1", busy2); end
      #2 reset = 1'b1;
      #1;
      ntests++; if ({ok2, err2, busy2, en2} !== 4'b0) begin nfail++; $display("FAIL rst_async_ctl got=%b exp=0000", {ok2, err2, busy2, en2}); end
      ntests++; if (inst2 !== 32'h0 || maddr2 !== 12'h0) begin nfail++; $display("FAIL rst_async_data inst=%h addr=%h exp 0 0", inst2, maddr2); end
      req2 = 1'b0;
      @(negedge clk) reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (ok2 || busy2) stray++;
      end
      ntests++; if (stray !== 0) begin nfail++; $display("FAIL rst_no_resp got=%0d exp=0", stray); end
   endtask

   initial begin
      step(); step();
      test_reset();
      @(negedge clk) reset = 1'b0;
      step();
      test_good_read();
      test_bad_addr();
      test_last_word();
      test_wait_states();
      test_flush();
      test_back_to_back();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
